// File: rtl/morse_char_decoder_if.sv
// rtl/morse_char_decoder_if.sv - symbol input and decoded character output bundle
interface morse_char_decoder_if #(
  parameter int MAX_LEN = 5,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
);
  logic             sym_valid;
  logic             sym_dash;
  logic             sym_end;
  logic             char_valid;
  logic             char_ready;
  logic [6:0]       char_out;
  logic             char_err;
  logic             char_drop;
  logic [CNT_W-1:0] sym_len;

  modport master (
    input  sym_valid, sym_dash, sym_end, char_ready,
    output char_valid, char_out, char_err, char_drop, sym_len
  );

  modport slave (
    output sym_valid, sym_dash, sym_end, char_ready,
    input  char_valid, char_out, char_err, char_drop, sym_len
  );
endinterface

// File: rtl/morse_char_decoder.sv
// rtl/morse_char_decoder.sv - dot/dash accumulator, Morse to ASCII decode, 2-entry output buffer
module morse_char_decoder #(
  parameter int MAX_LEN   = 5,
  parameter int DIGITS_EN = 1,
  parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  morse_char_decoder_if.master bus
);
  typedef struct packed {
    logic       err;
    logic [6:0] ascii;
  } entry_t;

  logic [MAX_LEN-1:0] pat;
  logic [CNT_W-1:0]   len;
  logic               ovf;
  entry_t             e0;
  entry_t             e1;
  logic [1:0]         count;
  logic               drop;

  logic [MAX_LEN-1:0] pat_nx;
  logic [CNT_W-1:0]   len_nx;
  logic               ovf_nx;
  logic               push;
  logic               pop;
  entry_t             dec;

  // Patterns are first-symbol-most-significant; dash = 1.
  function automatic entry_t decode(input logic [CNT_W-1:0] n,
                                    input logic [MAX_LEN-1:0] p_in,
                                    input logic bad);
    logic [4:0] p;
    logic [6:0] a;
    entry_t     r;
    p = 5'(p_in);
    a = 7'h3F;
    case (int'(n))
      1: a = p[0] ? 7'h54 : 7'h45;
      2: case (p[1:0])
        2'b00: a = 7'h49;
        2'b01: a = 7'h41;
        2'b10: a = 7'h4E;
        default: a = 7'h4D;
      endcase
      3: case (p[2:0])
        3'b000: a = 7'h53;
        3'b001: a = 7'h55;
        3'b010: a = 7'h52;
        3'b011: a = 7'h57;
        3'b100: a = 7'h44;
        3'b101: a = 7'h4B;
        3'b110: a = 7'h47;
        default: a = 7'h4F;
      endcase
      4: case (p[3:0])
        4'b0000: a = 7'h48;
        4'b0001: a = 7'h56;
        4'b0010: a = 7'h46;
        4'b0100: a = 7'h4C;
        4'b0110: a = 7'h50;
        4'b0111: a = 7'h4A;
        4'b1000: a = 7'h42;
        4'b1001: a = 7'h58;
        4'b1010: a = 7'h43;
        4'b1011: a = 7'h59;
        4'b1100: a = 7'h5A;
        4'b1101: a = 7'h51;
        default: a = 7'h3F;
      endcase
      5: if (DIGITS_EN != 0) begin
        case (p)
          5'b11111: a = 7'h30;
          5'b01111: a = 7'h31;
          5'b00111: a = 7'h32;
          5'b00011: a = 7'h33;
          5'b00001: a = 7'h34;
          5'b00000: a = 7'h35;
          5'b10000: a = 7'h36;
          5'b11000: a = 7'h37;
          5'b11100: a = 7'h38;
          5'b11110: a = 7'h39;
          default: a = 7'h3F;
        endcase
      end
      default: a = 7'h3F;
    endcase
    r.ascii = bad ? 7'h3F : a;
    r.err   = bad || (a == 7'h3F);
    return r;
  endfunction

  // A symbol arriving with the gap is folded in before the character closes.
  always_comb begin
    pat_nx = pat;
    len_nx = len;
    ovf_nx = ovf;
    if (bus.sym_valid) begin
      if (int'(len) < MAX_LEN) begin
        pat_nx = {pat[MAX_LEN-2:0], bus.sym_dash};
        len_nx = len + 1'b1;
      end else begin
        ovf_nx = 1'b1;
      end
    end
    push = bus.sym_end && (len_nx != '0);
    pop  = (count != 2'd0) && bus.char_ready;
    dec  = decode(len_nx, pat_nx, ovf_nx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
      drop  <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (push) begin
        pat <= '0;
        len <= '0;
        ovf <= 1'b0;
      end else begin
        pat <= pat_nx;
        len <= len_nx;
        ovf <= ovf_nx;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            e0    <= dec;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            e1    <= dec;
            count <= 2'd2;
          end else begin
            drop <= 1'b1;
          end
        end
        2'b01: begin
          // Head keeps its last value when the buffer drains.
          if (count == 2'd2) e0 <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= dec;
          end else begin
            e0 <= e1;
            e1 <= dec;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.char_valid = (count != 2'd0);
  assign bus.char_out   = e0.ascii;
  assign bus.char_err   = e0.err;
  assign bus.char_drop  = drop;
  assign bus.sym_len    = len;
endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Parametrised successor to the alphabet lookup ROM. It takes a serial stream of dot/dash symbols from the keying front end and accumulates each character internally. On each letter-gap strobe it decodes the full letter set, plus digits when enabled, into 7-bit ASCII. Decoded characters are queued in a 2-entry output buffer with a valid/ready handshake toward the display/UART stage.

## Interface
- MAX_LEN, default 5: maximum symbols per character; legal range 4..6. Digits need at least 5.
- DIGITS_EN, default 1: 1 decodes 5-symbol digits 0-9; 0 maps every 5- or 6-symbol pattern to error.
- CNT_W, default $clog2(MAX_LEN+1): derived width of the symbol counter; not overridden.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sym_valid  in  1  one-cycle strobe: a symbol is present.
- sym_dash  in  1  qualifies sym_valid: 0 = dot, 1 = dash.
- sym_end  in  1  one-cycle strobe: letter gap; closes the current character.
- char_valid  out  1  output buffer non-empty.
- char_ready  in  1  consumer accepts the head entry when char_valid is also high.
- char_out  out  7  ASCII code of the head entry.
- char_err  out  1  head entry is an undecodable or overflowed pattern.
- char_drop  out  1  one-cycle pulse: a completed character was discarded because the buffer was full.
- sym_len  out  CNT_W  number of symbols accumulated so far in the current character.

## Operation
- **Reset values.** While rst is high, every output is 0: char_valid, char_out, char_err, char_drop and sym_len. The pattern register, overflow flag and buffer are also cleared. Reset mid-character discards the partial pattern. Reset with the buffer full empties the buffer.
- **Pattern register.** MAX_LEN bits wide, plus the sym_len counter.
  - Each accepted symbol shifts the register left and enters at bit 0, so the first symbol ends up most significant.
  - Examples: A (.-) is len 2, pattern 01. T (-) is len 1, pattern 1. 0 (-----) is len 5, pattern 11111.
- **Accumulate.** On sym_valid with sym_len < MAX_LEN: shift in the symbol and increment sym_len.
- **Overflow.** On sym_valid with sym_len == MAX_LEN: the pattern is left unchanged and a sticky ovf flag is set for the current character.
- **Close with an empty pattern.** sym_end with sym_len == 0 (and no simultaneous sym_valid) is ignored. Nothing is emitted.
- **Close with symbols present.** sym_end with sym_len > 0 does the following:
  - decodes {sym_len, pattern} combinationally;
  - pushes {ascii, err} into the buffer;
  - clears the pattern, sym_len and ovf in the same edge.
- **Symbol and gap in the same cycle.** sym_valid together with sym_end: the symbol is included first, then the character closes. This is valid even when sym_len == 0, giving a 1-symbol character.
- **Decode table.**
  - Lengths 1..4: the 26 international Morse letters map to 0x41..0x5A.
  - Length 5 with DIGITS_EN=1: the ten digits map to 0x30..0x39.
  - Any other pattern, or any character with ovf set, produces char_out = 0x3F ('?') with char_err = 1.
- **Output buffer.** 2-entry FIFO; the head entry drives char_out and char_err.
  - Pop occurs when char_valid && char_ready.
  - Push into a full buffer with no simultaneous pop: the character is discarded, char_drop pulses for 1 cycle, and buffer contents are unchanged.
  - Push and pop in the same cycle on a full buffer: accepted, no drop.
  - Push and pop in the same cycle on a 1-entry buffer: the count stays at 1 and the new entry becomes the head.
- **Backpressure.** Symbol accumulation never stalls on output backpressure.

## Timing
- sym_end sampled at edge N with the buffer empty: char_valid = 1 and char_out is valid after edge N (visible in cycle N+1). Latency is 1 cycle.
- sym_len updates at the edge that samples sym_valid. It reads 0 in the cycle after a closing sym_end.
- char_out and char_err are stable while char_valid && !char_ready.
- After a pop, the next entry is presented in the following cycle. If the buffer is empty, char_valid drops and char_out/char_err hold their last value.
- char_drop is registered and asserts in the cycle after the discarded sym_end.
- Throughput: one character per cycle is sustainable when char_ready is held high.

## Test plan
- **Reset.** Hold rst for 2 cycles, then release. Expect all outputs 0. Then send sym_end alone: expect no char_valid and sym_len stays 0.
- **Letters.** Send dot, dash, sym_end with char_ready=1. Expect char_valid for 1 cycle with char_out=0x41 ('A') and char_err=0. Repeat for dash-only: expect 0x54 ('T').
- **Digits and mode.** Send dash x5 then sym_end.
  - DIGITS_EN=1: expect 0x30.
  - DIGITS_EN=0: expect 0x3F with char_err=1.
  - Send dot, dash, dash, dash, dot (len 5, no digit match): expect 0x3F with char_err=1.
- **Overflow.** MAX_LEN=5: send 7 dots then sym_end. Expect sym_len saturated at 5, char_out=0x3F, char_err=1, and the next character decodes cleanly.
- **Backpressure and drop.** With char_ready=0, send E, I, S (3 characters).
  - Expect char_drop to pulse on S.
  - Then raise char_ready: expect 0x45 then 0x49, then char_valid=0.
- **Simultaneous events.**
  - sym_valid(dash) with sym_end in the same cycle on an empty pattern: expect 'T'.
  - Full buffer with push and pop in the same cycle: expect no char_drop and correct ordering.
  - rst asserted with 3 symbols pending: expect sym_len=0 and no output.
